// File: rtl/colormapper_pipe_if.sv
// Valid/ready pixel stream bundle: data, start-of-frame (tuser) and end-of-line (tlast).
interface colormapper_pipe_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] data;
  logic          sof;
  logic          eol;
  logic          valid;
  logic          ready;

  modport master (output data, output sof, output eol, output valid, input  ready);
  modport slave  (input  data, input  sof, input  eol, input  valid, output ready);
endinterface

// File: rtl/colormapper_pipe.sv
// Three-stage iteration-count to RGB colour mapper with global-stall backpressure
// and per-frame configuration shadowing that travels with each pixel.
module colormapper_pipe #(
  parameter int unsigned ITER_W      = 8,
  parameter int unsigned MAX_ITER    = 160,
  parameter logic [23:0] COLOR1      = 24'hFFFFFF,
  parameter logic [23:0] INSET_COLOR = 24'h000000
) (
  input  logic                aclk,
  input  logic                aresetn,
  colormapper_pipe_if.slave   in_if,
  colormapper_pipe_if.master  out_if,
  input  logic [2:0]          cfg_mode,
  input  logic [23:0]         cfg_color2,
  input  logic                cfg_inset_en
);

  typedef enum logic [2:0] {
    MODE_SUNRISE  = 3'd0,
    MODE_BARBIE   = 3'd1,
    MODE_MIDNIGHT = 3'd2,
    MODE_MOON     = 3'd3,
    MODE_RETRO    = 3'd4,
    MODE_CITRUS   = 3'd5,
    MODE_GRADIENT = 3'd6,
    MODE_RAW      = 3'd7
  } mode_e;

  localparam logic [ITER_W:0] MAX_C = (ITER_W+1)'(MAX_ITER);

  logic adv, take, cfg_load;

  // active (shadowed) configuration
  mode_e       act_mode_q, act_mode_d;
  logic [23:0] act_c2_q,   act_c2_d;
  logic        act_ien_q,  act_ien_d;

  // S1: normalise
  logic        s1_v_q, s1_inset_q, s1_ien_q, s1_sof_q, s1_eol_q;
  logic [7:0]  s1_x8_q;
  mode_e       s1_mode_q;
  logic [23:0] s1_c2_q;
  logic [7:0]  x8_d;
  logic        inset_d;

  // S2: multiply
  logic              s2_v_q, s2_inset_q, s2_ien_q, s2_sof_q, s2_eol_q;
  logic [7:0]        s2_x8_q;
  mode_e             s2_mode_q;
  logic signed [16:0] s2_p_q [3];
  logic signed [16:0] p_d    [3];
  logic signed [8:0]  dif;
  logic signed [17:0] prod;

  // S3: combine/select (output register)
  logic        out_valid_q, out_sof_q, out_eol_q;
  logic [23:0] out_rgb_q, rgb_d, mapped, grad;
  logic signed [9:0] sum;

  assign adv         = ~out_valid_q | out_if.ready;
  assign take        = in_if.valid & adv;
  assign in_if.ready = adv;

  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_rgb_q;
  assign out_if.sof   = out_sof_q;
  assign out_if.eol   = out_eol_q;

  // The sof pixel itself must already see the freshly latched config.
  always_comb begin
    cfg_load   = take & in_if.sof;
    act_mode_d = cfg_load ? mode_e'(cfg_mode) : act_mode_q;
    act_c2_d   = cfg_load ? cfg_color2        : act_c2_q;
    act_ien_d  = cfg_load ? cfg_inset_en      : act_ien_q;
  end

  generate
    if (ITER_W >= 8) begin : g_wide
      assign x8_d = in_if.data[ITER_W-1 -: 8];
    end else begin : g_narrow
      assign x8_d = 8'(in_if.data) << (8 - ITER_W);
    end
  endgenerate

  assign inset_d = ({1'b0, in_if.data} >= MAX_C);

  always_comb begin
    p_d  = '{default: '0};
    dif  = '0;
    prod = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      dif    = 9'(s1_c2_q[8*i +: 8]) - 9'(COLOR1[8*i +: 8]);
      prod   = 18'(dif) * 18'($signed({1'b0, s1_x8_q}));
      p_d[i] = prod[16:0];
    end
  end

  // p[16:8] is p >>> 8 (floor); c1 + that always lands in 0..255.
  always_comb begin
    grad = '0;
    sum  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      sum             = 10'($signed({2'b00, COLOR1[8*i +: 8]})) + 10'($signed(s2_p_q[i][16:8]));
      grad[8*i +: 8]  = sum[7:0];
    end
  end

  always_comb begin
    mapped = '0;
    unique case (s2_mode_q)
      MODE_SUNRISE:  mapped = {1'b1, s2_x8_q[7:1], 1'b0, ~s2_x8_q[7:1], 2'b00, s2_x8_q[7:2]};
      MODE_BARBIE:   mapped = {3'b111, ~s2_x8_q[7:3], ~s2_x8_q, 1'b1, ~s2_x8_q[7:1]};
      MODE_MIDNIGHT: mapped = {2'b00, ~s2_x8_q[7:2], 1'b0, s2_x8_q[7:1], 2'b01, s2_x8_q[7:2]};
      MODE_MOON:     mapped = {s2_x8_q, s2_x8_q, s2_x8_q};
      MODE_RETRO:    mapped = {8'h00, s2_x8_q, 8'h00};
      MODE_CITRUS:   mapped = {~s2_x8_q[7:6], 1'b1, ~s2_x8_q[4:0], 2'b11, s2_x8_q[7], 5'b11111, 8'h00};
      MODE_GRADIENT: mapped = grad;
      MODE_RAW:      mapped = {8'h00, s2_x8_q, s2_x8_q};
      default:       mapped = '0;
    endcase
    rgb_d = (s2_inset_q & s2_ien_q) ? INSET_COLOR : mapped;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      act_mode_q  <= MODE_SUNRISE;
      act_c2_q    <= '0;
      act_ien_q   <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_x8_q     <= '0;
      s1_inset_q  <= 1'b0;
      s1_mode_q   <= MODE_SUNRISE;
      s1_c2_q     <= '0;
      s1_ien_q    <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_x8_q     <= '0;
      s2_inset_q  <= 1'b0;
      s2_mode_q   <= MODE_SUNRISE;
      s2_ien_q    <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_eol_q    <= 1'b0;
      s2_p_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      act_mode_q <= act_mode_d;
      act_c2_q   <= act_c2_d;
      act_ien_q  <= act_ien_d;
      if (adv) begin
        s1_v_q      <= in_if.valid;
        s1_x8_q     <= x8_d;
        s1_inset_q  <= inset_d;
        s1_mode_q   <= act_mode_d;
        s1_c2_q     <= act_c2_d;
        s1_ien_q    <= act_ien_d;
        s1_sof_q    <= in_if.sof;
        s1_eol_q    <= in_if.eol;
        s2_v_q      <= s1_v_q;
        s2_x8_q     <= s1_x8_q;
        s2_inset_q  <= s1_inset_q;
        s2_mode_q   <= s1_mode_q;
        s2_ien_q    <= s1_ien_q;
        s2_sof_q    <= s1_sof_q;
        s2_eol_q    <= s1_eol_q;
        s2_p_q      <= p_d;
        out_valid_q <= s2_v_q;
        out_rgb_q   <= rgb_d;
        out_sof_q   <= s2_sof_q;
        out_eol_q   <= s2_eol_q;
      end
    end
  end

endmodule

// File: tb/tb_colormapper_pipe.sv
// Scoreboard bench for colormapper_pipe: driver pushes model results, monitor pops on output beats.
`timescale 1ns/1ps
module tb_colormapper_pipe;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [2:0]  cfg_mode;
  logic [23:0] cfg_color2;
  logic        cfg_inset_en;

  colormapper_pipe_if #(.DW(8))  in_if ();
  colormapper_pipe_if #(.DW(24)) out_if ();

  colormapper_pipe #(
    .ITER_W(8), .MAX_ITER(160), .COLOR1(24'hFFFFFF), .INSET_COLOR(24'h000000)
  ) dut (
    .aclk(clk), .aresetn(aresetn), .in_if(in_if), .out_if(out_if),
    .cfg_mode(cfg_mode), .cfg_color2(cfg_color2), .cfg_inset_en(cfg_inset_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    logic        sof;
    logic        eol;
    int          stamp;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   lat_chk = 1'b0;
  bit   rnd_done = 1'b0;

  // reference config shadow
  int          m_mode;
  logic [23:0] m_c2;
  bit          m_ien;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fdiv256(input int p);
    int r;
    r = p / 256;
    if ((p % 256) != 0 && p < 0) r = r - 1;
    return r;
  endfunction

  function automatic logic [23:0] model(input int iter, input int mode, input logic [23:0] c2, input bit ien);
    int x, r, g, b, c2ch;
    int ch [3];
    x = iter;
    if (ien && iter >= 160) return 24'h000000;
    r = 0; g = 0; b = 0;
    case (mode)
      0: begin r = 128 + x/2;      g = 127 - x/2;   b = x/4;        end
      1: begin r = 224 + 31 - x/8; g = 255 - x;     b = 255 - x/2;  end
      2: begin r = 63 - x/4;       g = x/2;         b = 64 + x/4;   end
      3: begin r = x; g = x; b = x; end
      4: begin g = x; end
      5: begin r = (3 - x/64)*64 + 32 + (31 - x%32); g = 192 + (x/128)*32 + 31; end
      6: begin
        for (int i = 0; i < 3; i++) begin
          c2ch  = (c2 >> (16 - 8*i)) & 255;
          ch[i] = 255 + fdiv256((c2ch - 255) * x);
        end
        r = ch[0]; g = ch[1]; b = ch[2];
      end
      default: begin g = x; b = x; end
    endcase
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic send(input int iter, input bit sof, input bit eol,
                      input int mode, input logic [23:0] c2, input bit ien);
    bit   hs = 0;
    int   n  = 0;
    exp_t e;
    in_if.data   = iter[7:0];
    in_if.sof    = sof;
    in_if.eol    = eol;
    in_if.valid  = 1'b1;
    cfg_mode     = mode[2:0];
    cfg_color2   = c2;
    cfg_inset_en = ien;
    while (!hs) begin
      @(negedge clk);
      if (in_if.ready) begin
        hs = 1;
        if (sof) begin m_mode = mode; m_c2 = c2; m_ien = ien; end
        e.rgb = model(iter, m_mode, m_c2, m_ien);
        e.sof = sof; e.eol = eol; e.stamp = cyc; e.lat = lat_chk;
        q.push_back(e);
      end
      @(posedge clk); #1;
      n++;
      if (!hs && n > 200) begin
        check("handshake_timeout", 0, 1);
        break;
      end
    end
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin @(posedge clk); n++; end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // monitor: scoreboard pop, hold-while-stalled, intake blocked while stalled
  logic [25:0] held;
  bit          stall_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!aresetn) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", out_if.valid, 1);
        check("hold_data", {out_if.data, out_if.sof, out_if.eol}, held);
      end
      if (out_if.valid && !out_if.ready) begin
        check("stall_in_ready", in_if.ready, 0);
        held    = {out_if.data, out_if.sof, out_if.eol};
        stall_q = 1'b1;
      end else begin
        stall_q = 1'b0;
      end
      if (out_if.valid && out_if.ready) begin
        if (q.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          e = q.pop_front();
          check("rgb", out_if.data, e.rgb);
          check("sof", out_if.sof, e.sof);
          check("eol", out_if.eol, e.eol);
          if (e.lat) check("latency", cyc - e.stamp, 3);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int it, md, gap;
    bit sf;
    aresetn      = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.sof    = 1'b0;
    in_if.eol    = 1'b0;
    out_if.ready = 1'b1;
    cfg_mode     = 3'd5;
    cfg_color2   = 24'h123456;
    cfg_inset_en = 1'b1;
    m_mode = 0; m_c2 = '0; m_ien = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_rgb",   out_if.data, 0);
    check("rst_out_sof",   out_if.sof, 0);
    check("rst_out_eol",   out_if.eol, 0);
    check("rst_in_ready",  in_if.ready, 1);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;

    // single beat, moon, latency 3
    lat_chk = 1'b1;
    send(8'h5A, 1, 1, 3, 24'h0, 0);
    drain();

    // gradient white -> black
    send(128, 1, 0, 6, 24'h000000, 0);
    send(0,   0, 0, 6, 24'h000000, 0);
    send(255, 0, 1, 6, 24'h000000, 0);
    send(64,  1, 0, 6, 24'h40A0FF, 0);
    send(200, 0, 1, 6, 24'h40A0FF, 0);
    drain();

    // in-set boundary
    send(160, 1, 0, 0, 24'h0, 1);
    send(159, 0, 0, 0, 24'h0, 1);
    send(255, 0, 1, 0, 24'h0, 1);
    send(200, 1, 1, 2, 24'h0, 0);
    drain();

    // frame switch with A's tail in flight; mid-frame cfg changes ignored
    send(10, 1, 0, 4, 24'h0, 0);
    send(20, 0, 0, 3, 24'hFFFFFF, 1);
    send(30, 0, 0, 6, 24'h0, 0);
    send(40, 0, 1, 1, 24'h0, 0);
    send(50, 1, 0, 3, 24'h0, 0);
    send(60, 0, 0, 4, 24'h0, 1);
    send(70, 0, 1, 5, 24'h0, 0);
    drain();

    // backpressure burst of 10 with a 4-cycle stall
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(i * 23 + 5, (i == 0), (i == 9), 7, 24'h0, 0);
      end
      begin
        repeat (4) @(posedge clk); #1;
        out_if.ready = 1'b0;
        repeat (4) @(posedge clk); #1;
        out_if.ready = 1'b1;
      end
    join
    drain();

    // reset with beats in flight
    send(1, 1, 0, 3, 24'h0, 1);
    send(2, 0, 0, 3, 24'h0, 1);
    send(3, 0, 0, 3, 24'h0, 1);
    aresetn = 1'b0;
    q.delete();
    @(posedge clk); #1;
    aresetn = 1'b1;
    m_mode = 0; m_c2 = '0; m_ien = 0;
    @(negedge clk);
    check("postrst_out_valid", out_if.valid, 0);
    check("postrst_in_ready",  in_if.ready, 1);
    @(posedge clk); #1;
    lat_chk = 1'b1;
    send(200, 0, 1, 3, 24'hFFFFFF, 1);
    drain();

    // randomized traffic with random backpressure
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          sf = (i == 0) || ($urandom_range(0, 7) == 0);
          md = $urandom_range(0, 7);
          it = ($urandom_range(0, 3) == 0) ? $urandom_range(157, 163) : $urandom_range(0, 255);
          send(it, sf, ($urandom_range(0, 5) == 0), md, 24'($urandom), $urandom_range(0, 1) == 1);
          gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
          repeat (gap) begin @(posedge clk); #1; end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_if.ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_if.ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
